mem_arb_4r1w: RTL and testbench

Single-clock memory with one write port and four read requesters sharing one physical read port through a round-robin arbiter. It is the read-side counterpart of the multi-writer memory block. Four independent consumers each issue valid/ready read requests and get registered, one-cycle-latency responses, while a single producer writes. Its default parameters match the existing memory blocks, so the two can be paired in the same datapath.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/rr_arb4.sv | 31 +++
 rtl/mem_arb_4r1w.sv | 107 ++++++++++
 tb/tb_mem_arb_4r1w.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and types for the 4-reader/1-writer memory.
// Holds the requester count, requester index type and arbiter reset pointer.
package mem_arb_pkg;

    localparam int NUM_RD = 4;

    typedef logic [1:0] rd_idx_t;

    // Pointer starts at the last requester so requester 0 wins first.
    localparam rd_idx_t RR_RESET_PTR = 2'd3;

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: pure combinational 4-way round-robin arbiter.
// Searches upward from ptr+1 (mod 4); the pointer register lives in the parent.
module rr_arb4
    import mem_arb_pkg::*;
(
    input  logic [NUM_RD-1:0] req,
    input  rd_idx_t           ptr,
    output logic [NUM_RD-1:0] gnt,
    output rd_idx_t           gnt_idx,
    output logic              any_gnt
);

    rd_idx_t cand;

    // First requester found after ptr wins; offset 4 wraps back onto ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = ptr;
        for (int k = 1; k <= NUM_RD; k++) begin
            cand = ptr + rd_idx_t'(k);
            if (!any_gnt && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                any_gnt   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb_4r1w.sv
// mem_arb_4r1w: one write port, four round-robin arbitrated read requesters.
// Define MEM_ARB_4R1W_FWD_EN to forward same-cycle write data to the read.
module mem_arb_4r1w
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_RD-1:0]            req_valid,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_RD-1:0]            req_ready,
    output logic [NUM_RD-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    rd_idx_t               last_grant_q;
    rd_idx_t               last_grant_d;
    logic [NUM_RD-1:0]     rsp_valid_q;
    logic [NUM_RD-1:0]     rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [DATA_WIDTH-1:0] rsp_data_d;

    logic [NUM_RD-1:0]     gnt;
    rd_idx_t               gnt_idx;
    logic                  any_gnt;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rd_word;

    rr_arb4 u_arb (
        .req     (req_valid),
        .ptr     (last_grant_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign req_ready = gnt;

    // Select the granted requester's address slice.
    always_comb begin
        raddr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (gnt[i]) begin
                raddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

`ifdef MEM_ARB_4R1W_FWD_EN
    // Same-cycle write to the read address returns the new data.
    always_comb begin
        rd_word = mem_q[raddr];
        if (we && (waddr == raddr)) begin
            rd_word = wdata;
        end
    end
`else
    // Read-before-write: the array is sampled before this edge's write.
    always_comb begin
        rd_word = mem_q[raddr];
    end
`endif

    // Pointer moves only on acceptance; response data holds when idle.
    always_comb begin
        last_grant_d = last_grant_q;
        rsp_valid_d  = gnt;
        rsp_data_d   = rsp_data_q;
        if (any_gnt) begin
            last_grant_d = gnt_idx;
            rsp_data_d   = rd_word;
        end
    end

    // Arbiter pointer and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= RR_RESET_PTR;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Write port; never stalled and not gated by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_arb_4r1w.sv
// tb_mem_arb_4r1w: scenario tasks plus a randomized run against a
// behavioural model of the arbitrated 4-reader/1-writer memory.
module tb_mem_arb_4r1w;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    req_valid = '0;
    logic [4*AW-1:0] req_addr = '0;
    logic [3:0]    req_ready;
    logic [3:0]    rsp_valid;
    logic [DW-1:0] rsp_data;

    int n_tests = 0;
    int n_fail = 0;
    int proto_err = 0;

    // Behavioural model state.
    logic [DW-1:0] m_mem [16];
    int            m_last = 3;
    logic [3:0]    m_rv = '0;
    logic [DW-1:0] m_rd = '0;
    int            m_g = -1;
    logic [3:0]    p_pend = '0;
    logic [AW-1:0] p_addr [4];

    mem_arb_4r1w #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    // Round-robin rule: first valid requester after the last grant.
    function automatic int exp_grant(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input logic [3:0] v,
                                             input int last);
        int g;
        g = exp_grant(v, last);
        if (g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    // Model update at each rising edge, plus requester stability check.
    always @(posedge clk) begin : model
        int            g;
        logic [AW-1:0] a;
        logic [DW-1:0] rdv;
        for (int i = 0; i < 4; i++) begin
            if (p_pend[i] && (!req_valid[i] ||
                req_addr[i*AW +: AW] !== p_addr[i])) begin
                proto_err++;
                $display("FAIL protocol port %0d dropped before accept", i);
            end
        end
        g = exp_grant(req_valid, m_last);
        a = (g >= 0) ? req_addr[g*AW +: AW] : '0;
        rdv = m_mem[a];
`ifdef MEM_ARB_4R1W_FWD_EN
        if (we && waddr == a) rdv = wdata;
`endif
        if (rst) begin
            m_rv = '0;
            m_rd = '0;
            m_last = 3;
        end else if (g >= 0) begin
            m_rv = 4'b0001 << g;
            m_rd = rdv;
            m_last = g;
        end else begin
            m_rv = '0;
        end
        if (we) m_mem[waddr] = wdata;
        for (int i = 0; i < 4; i++) begin
            p_pend[i] = req_valid[i] && (g != i);
            p_addr[i] = req_addr[i*AW +: AW];
        end
        m_g = g;
    end

    // Keep pending requests asserted until every one is accepted.
    task automatic drain();
        int n;
        n = 0;
        while (p_pend != 4'b0 && n < 16) begin
            @(negedge clk);
            we = 1'b0;
            req_valid = p_pend;
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (p_pend != 4'b0) begin
            n_fail++;
            $display("FAIL drain: pending %b, want 0000", p_pend);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        we = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        we = 1'b1;
        waddr = 4'd0;
        wdata = 8'hA5;
        req_valid = '0;
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 4'b0 || rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out: got %b/%h, want 0000/00",
                     rsp_valid, rsp_data);
        end
        @(negedge clk);
        we = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 1; a < 16; a++) begin
            @(negedge clk);
            we = 1'b1;
            waddr = 4'(a);
            wdata = 8'($urandom);
        end
        @(negedge clk);
        we = 1'b0;
        req_valid = 4'b0100;
        req_addr[2*AW +: AW] = 4'd0;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_first_gnt: got %b, want 0100", req_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_in_reset: got %b/%h, want 0100/a5",
                     rsp_valid, rsp_data);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = '0;
        we = 1'b1;
        waddr = 4'd5;
        wdata = 8'h01;
        @(negedge clk);
        we = 1'b0;
        req_valid = 4'b0001;
        req_addr[0 +: AW] = 4'd5;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b, want 0001", req_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 8'h01) begin
            n_fail++;
            $display("FAIL single_rsp: got %b/%h, want 0001/01",
                     rsp_valid, rsp_data);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] pat [4];
        logic [3:0]    want;
        pat = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            we = 1'b1;
            waddr = 4'(i + 1);
            wdata = pat[i];
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            we = 1'b0;
            req_valid = 4'hF;
            for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = 4'(i + 1);
            want = 4'b0001 << (k % 4);
            #1;
            n_tests++;
            if (req_ready !== want) begin
                n_fail++;
                $display("FAIL rr_ready k=%0d: got %b, want %b",
                         k, req_ready, want);
            end
            @(posedge clk); #1;
            n_tests++;
            if (rsp_valid !== want || rsp_data !== pat[k % 4]) begin
                n_fail++;
                $display("FAIL rr_rsp k=%0d: got %b/%h, want %b/%h",
                         k, rsp_valid, rsp_data, want, pat[k % 4]);
            end
        end
        drain();
    endtask

    task automatic test_sparse();
        logic [3:0] want;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = 4'b1010;
            req_addr[1*AW +: AW] = 4'd2;
            req_addr[3*AW +: AW] = 4'd4;
            want = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            #1;
            n_tests++;
            if (req_ready !== want) begin
                n_fail++;
                $display("FAIL sparse k=%0d: got %b, want %b",
                         k, req_ready, want);
            end
            @(posedge clk); #1;
            n_tests++;
            if (rsp_valid !== m_rv || rsp_data !== m_rd) begin
                n_fail++;
                $display("FAIL sparse_rsp k=%0d: got %b/%h, want %b/%h",
                         k, rsp_valid, rsp_data, m_rv, m_rd);
            end
        end
        drain();
    endtask

    task automatic test_rdw();
        logic [DW-1:0] want;
`ifdef MEM_ARB_4R1W_FWD_EN
        want = 8'h01;
`else
        want = 8'h00;
`endif
        @(negedge clk);
        req_valid = '0;
        we = 1'b1;
        waddr = 4'd7;
        wdata = 8'h00;
        @(negedge clk);
        we = 1'b1;
        waddr = 4'd7;
        wdata = 8'h01;
        req_valid = 4'b0001;
        req_addr[0 +: AW] = 4'd7;
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_data !== want) begin
            n_fail++;
            $display("FAIL rdw_same: got %b/%h, want 0001/%h",
                     rsp_valid, rsp_data, want);
        end
        @(negedge clk);
        we = 1'b0;
        req_valid = 4'b0010;
        req_addr[1*AW +: AW] = 4'd7;
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 8'h01) begin
            n_fail++;
            $display("FAIL rdw_next: got %b/%h, want 0010/01",
                     rsp_valid, rsp_data);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = '0;
        we = 1'b1;
        waddr = 4'd9;
        wdata = 8'h3C;
        @(negedge clk);
        we = 1'b0;
        rst = 1'b1;
        req_valid = 4'b0100;
        req_addr[2*AW +: AW] = 4'd9;
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 4'b0 || rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got %b/%h, want 0000/00",
                     rsp_valid, rsp_data);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = 4'd9;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_mid_gnt: got %b, want 0001", req_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL reset_mid_mem: got %b/%h, want 0001/3c",
                     rsp_valid, rsp_data);
        end
        drain();
    endtask

    task automatic test_hold();
        logic [3:0] vals [5];
        logic [3:0] wants [5];
        vals  = '{4'b0010, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
        wants = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = vals[k];
            req_addr[1*AW +: AW] = 4'd3;
            req_addr[2*AW +: AW] = 4'd4;
            #1;
            n_tests++;
            if (req_ready !== wants[k]) begin
                n_fail++;
                $display("FAIL hold k=%0d: got %b, want %b",
                         k, req_ready, wants[k]);
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_random();
        logic [3:0]    pend;
        logic [AW-1:0] a [4];
        int            waitc [4];
        logic [3:0]    er;
        pend = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = '0;
            waitc[i] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    a[i] = 4'($urandom_range(15, 0));
                end
                req_addr[i*AW +: AW] = a[i];
            end
            req_valid = pend;
            we = 1'($urandom_range(1, 0));
            if ($urandom_range(3, 0) == 0)
                waddr = a[$urandom_range(3, 0)];
            else
                waddr = 4'($urandom_range(15, 0));
            wdata = 8'($urandom);
            er = exp_ready(req_valid, m_last);
            #1;
            n_tests++;
            if (req_ready !== er) begin
                n_fail++;
                $display("FAIL rand_ready n=%0d: got %b, want %b",
                         n, req_ready, er);
            end
            @(posedge clk); #1;
            n_tests++;
            if (rsp_valid !== m_rv || rsp_data !== m_rd) begin
                n_fail++;
                $display("FAIL rand_rsp n=%0d: got %b/%h, want %b/%h",
                         n, rsp_valid, rsp_data, m_rv, m_rd);
            end
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && m_g == i) begin
                    pend[i] = 1'b0;
                    waitc[i] = 0;
                end else if (pend[i]) begin
                    waitc[i]++;
                    if (waitc[i] >= 4) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL fairness port %0d: waited %0d, max 3",
                                 i, waitc[i]);
                        waitc[i] = 0;
                    end
                end
            end
        end
        we = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_sparse();
        test_rdw();
        test_reset_mid();
        test_hold();
        test_random();
        n_tests++;
        if (proto_err != 0) begin
            n_fail++;
            $display("FAIL protocol: got %0d violations, want 0", proto_err);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
